// File: rtl/uart_rx_cfg.sv
// Oversampled RS-232 receiver with configurable width, parity and ratio; valid/ready output with error flags.
// UART_RX_BREAK_DET_EN adds an rx_break output and a BREAK state that swallows all-zero framing-error frames.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 921600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
`ifdef UART_RX_BREAK_DET_EN
    output logic                 rx_break,
`endif
    output logic                 rx_busy
);
    localparam int DIV_RAW = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_BITS);
    localparam int MID     = OVERSAMPLE / 2;

    localparam logic [TW-1:0] T_V0   = TW'(MID - 1);
    localparam logic [TW-1:0] T_V1   = TW'(MID);
    localparam logic [TW-1:0] T_SP   = TW'(MID + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

`ifdef UART_RX_BREAK_DET_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`endif

    state_t                 state_q;
    logic                   sync1_q, rxd_s_q, rxd_prev_q;
    logic [DW-1:0]          div_q, div_d;
    logic [TW-1:0]          tcnt_q;
    logic [BW-1:0]          bcnt_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   par_q, v0_q, v1_q, busy_q;
    logic                   dlv_q, dlv_perr_q, dlv_ferr_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q, perr_q, ferr_q, ovr_q;
    logic                   tick, start_edge, sample_pt, bit_val, perr;

    assign start_edge = !rxd_s_q && rxd_prev_q;
    assign tick       = (div_q == DW'(DIV - 1));
    assign sample_pt  = tick && (tcnt_q == T_SP);
    assign bit_val    = (v0_q & v1_q) | (v0_q & rxd_s_q) | (v1_q & rxd_s_q);
    assign perr       = (PARITY == 1) ? !(^shreg_q ^ par_q) :
                        (PARITY == 2) ?  (^shreg_q ^ par_q) : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            rxd_s_q    <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            sync1_q    <= rxd;
            rxd_s_q    <= sync1_q;
            rxd_prev_q <= rxd_s_q;
        end
    end

    // Restarting the divider on the start edge aligns every later tick to the line edge.
    always_comb begin
        div_d = div_q + DW'(1);
        if ((state_q == S_IDLE && start_edge) || tick) div_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_q <= '0;
        else        div_q <= div_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tcnt_q     <= '0;
            bcnt_q     <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            v0_q       <= 1'b0;
            v1_q       <= 1'b0;
            busy_q     <= 1'b0;
            dlv_q      <= 1'b0;
            dlv_perr_q <= 1'b0;
            dlv_ferr_q <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            rx_break   <= 1'b0;
`endif
        end else begin
            dlv_q <= 1'b0;
            if (tick && tcnt_q == T_V0) v0_q <= rxd_s_q;
            if (tick && tcnt_q == T_V1) v1_q <= rxd_s_q;
            case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        state_q <= S_START;
                        tcnt_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (tick) tcnt_q <= tcnt_q + TW'(1);
                    if (sample_pt) begin
                        if (!bit_val) begin
                            state_q <= S_DATA;
                            bcnt_q  <= '0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) tcnt_q <= tcnt_q + TW'(1);
                    if (sample_pt) begin
                        shreg_q <= {bit_val, shreg_q[DATA_BITS-1:1]};
                        if (bcnt_q == BW'(DATA_BITS - 1)) state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                        else                              bcnt_q  <= bcnt_q + BW'(1);
                    end
                end
                S_PARITY: begin
                    if (tick) tcnt_q <= tcnt_q + TW'(1);
                    if (sample_pt) begin
                        par_q   <= bit_val;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick) tcnt_q <= tcnt_q + TW'(1);
                    // Leaving at mid-stop keeps a back-to-back start edge visible in IDLE.
                    if (sample_pt) begin
`ifdef UART_RX_BREAK_DET_EN
                        if (!bit_val && shreg_q == '0) begin
                            state_q  <= S_BREAK;
                            tcnt_q   <= '0;
                            rx_break <= 1'b1;
                        end else
`endif
                        begin
                            state_q    <= S_IDLE;
                            busy_q     <= 1'b0;
                            dlv_q      <= 1'b1;
                            dlv_ferr_q <= !bit_val;
                            dlv_perr_q <= perr;
                        end
                    end
                end
`ifdef UART_RX_BREAK_DET_EN
                S_BREAK: begin
                    if (!rxd_s_q) begin
                        tcnt_q <= '0;
                    end else if (tick) begin
                        if (tcnt_q == T_LAST) begin
                            state_q  <= S_IDLE;
                            busy_q   <= 1'b0;
                            rx_break <= 1'b0;
                            tcnt_q   <= '0;
                        end else begin
                            tcnt_q <= tcnt_q + TW'(1);
                        end
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // A delivery in the same cycle as an accept replaces the held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (dlv_q) begin
                if (!valid_q || rx_ready) begin
                    data_q  <= shreg_q;
                    perr_q  <= dlv_perr_q;
                    ferr_q  <= dlv_ferr_q;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
            end
        end
    end

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign rx_parity_err = perr_q;
    assign rx_frame_err  = ferr_q;
    assign rx_overrun    = ovr_q;
    assign rx_busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: an 8N1 instance and a 7E1 instance, checked against a frame-level model.
module tb_uart_rx_cfg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, rxd0, rxd1, rdy;
    logic [7:0] d0;
    logic [6:0] d1;
    logic       v0, pe0, fe0, ov0, b0;
    logic       v1, pe1, fe1, ov1, b1;
`ifdef UART_RX_BREAK_DET_EN
    logic       brk0, brk1;
`endif

    uart_rx_cfg #(.CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd0), .rx_data(d0), .rx_valid(v0), .rx_ready(rdy),
        .rx_parity_err(pe0), .rx_frame_err(fe0), .rx_overrun(ov0),
`ifdef UART_RX_BREAK_DET_EN
        .rx_break(brk0),
`endif
        .rx_busy(b0));

    uart_rx_cfg #(.CLK_FREQ(1600000), .BAUD(100000), .OVERSAMPLE(16), .DATA_BITS(7), .PARITY(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd1), .rx_data(d1), .rx_valid(v1), .rx_ready(rdy),
        .rx_parity_err(pe1), .rx_frame_err(fe1), .rx_overrun(ov1),
`ifdef UART_RX_BREAK_DET_EN
        .rx_break(brk1),
`endif
        .rx_busy(b1));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int sel      = 0;
    int last_t0  = 0;

    logic [10:0] expq[$];
    logic [10:0] cur = '0;
    logic [8:0]  last_data = '0;
    logic        last_perr = 1'b0, last_ferr = 1'b0, last_busy = 1'b0;
    int          last_lat = 0, last_len = 0, ov_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle comparison of the selected receiver against the expected-word queue.
    initial begin : compare
        logic       pv, pr, v, pe, fe, ov, b, vo, ovo;
        logic [8:0] dat;
        pv = 1'b0;
        pr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
            end else begin
                v   = sel ? v1 : v0;
                dat = sel ? {2'b0, d1} : {1'b0, d0};
                pe  = sel ? pe1 : pe0;
                fe  = sel ? fe1 : fe0;
                ov  = sel ? ov1 : ov0;
                b   = sel ? b1 : b0;
                vo  = sel ? v0 : v1;
                ovo = sel ? ov0 : ov1;
                chk("idle_instance_quiet", {30'd0, vo, ovo}, 32'd0);
                if (v && (!pv || pr)) begin
                    if (expq.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_word: got data %0h, expected no word (cycle %0d)", dat, cyc);
                    end else begin
                        cur = expq.pop_front();
                    end
                    last_data = dat;
                    last_perr = pe;
                    last_ferr = fe;
                    last_busy = b;
                    last_lat  = cyc - last_t0;
                    last_len  = 0;
                end
                if (v) begin
                    last_len++;
                    chk("word", {21'd0, fe, pe, dat}, {21'd0, cur});
                end else begin
                    chk("flags_clear", {30'd0, pe, fe}, 32'd0);
                end
                if (ov) ov_cnt++;
                pv = v;
                pr = rdy;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input int s, input logic bv);
        if (s != 0) rxd1 = bv;
        else        rxd0 = bv;
        repeat (16) @(posedge clk);
        #1;
    endtask

    // Builds the expected word from the frame contents, then drives the frame one bit per 16 clks.
    task automatic send(input int s, input logic [8:0] data, input bit pflip, input bit stopb, input bit deliver);
        int         db, pm, ones;
        logic [8:0] d;
        logic       p, perr;
        db   = (s != 0) ? 7 : 8;
        pm   = (s != 0) ? 2 : 0;
        d    = data & ((9'h1 << db) - 9'h1);
        ones = $countones(d);
        p    = (pm == 2) ? ones[0] : ~ones[0];
        p    = p ^ pflip;
        perr = (pm == 0) ? 1'b0 : (pm == 2) ? (((ones + int'(p)) % 2) == 1) : (((ones + int'(p)) % 2) == 0);
        if (deliver) expq.push_back({~stopb, perr, d});
        @(posedge clk);
        #1;
        last_t0 = cyc;
        bit_out(s, 1'b0);
        for (int i = 0; i < db; i++) bit_out(s, d[i]);
        if (pm != 0) bit_out(s, p);
        bit_out(s, stopb);
    endtask

    initial begin
        rst_n = 1'b0;
        rxd0  = 1'b1;
        rxd1  = 1'b1;
        rdy   = 1'b1;
        idle(3);
        chk("reset_outputs0", {22'd0, d0, v0, pe0, fe0, ov0, b0}, 32'd0);
        chk("reset_outputs1", {23'd0, d1, v1, pe1, fe1, ov1, b1}, 32'd0);
`ifdef UART_RX_BREAK_DET_EN
        chk("reset_break", {30'd0, brk0, brk1}, 32'd0);
`endif
        rst_n = 1'b1;
        idle(20);

        // 8N1 0xA5: valid 158 clks after the line falls, one-clk pulse, busy already low.
        send(0, 9'h0A5, 1'b0, 1'b1, 1'b1);
        idle(20);
        chk("a5_data", 32'(last_data), 32'h0A5);
        chk("a5_flags", {30'd0, last_perr, last_ferr}, 32'd0);
        chk("a5_latency", 32'(last_lat), 32'd158);
        chk("a5_pulse_len", 32'(last_len), 32'd1);
        chk("a5_busy_low", 32'(last_busy), 32'd0);
        chk("queue_empty_a5", 32'(expq.size()), 32'd0);

        // 7E1 0x41: two ones, parity bit 0 is correct, 1 is wrong.
        sel = 1;
        idle(2);
        send(1, 9'h041, 1'b0, 1'b1, 1'b1);
        idle(20);
        chk("e7_good_data", 32'(last_data), 32'h041);
        chk("e7_good_perr", 32'(last_perr), 32'd0);
        send(1, 9'h041, 1'b1, 1'b1, 1'b1);
        idle(20);
        chk("e7_bad_data", 32'(last_data), 32'h041);
        chk("e7_bad_perr", 32'(last_perr), 32'd1);
        sel = 0;
        idle(2);

        // Low stop bit still delivers the word with a frame error.
        send(0, 9'h03C, 1'b0, 1'b0, 1'b1);
        rxd0 = 1'b1;
        idle(20);
        chk("fe_data", 32'(last_data), 32'h03C);
        chk("fe_flag", 32'(last_ferr), 32'd1);

`ifdef UART_RX_BREAK_DET_EN
        send(0, 9'h000, 1'b0, 1'b0, 1'b0);
        idle(39 * 16);
        chk("break_set", 32'(brk0), 32'd1);
        rxd0 = 1'b1;
        idle(10);
        chk("break_held", 32'(brk0), 32'd1);
        idle(15);
        chk("break_released", {30'd0, brk0, b0}, 32'd0);
`else
        send(0, 9'h000, 1'b0, 1'b0, 1'b1);
        rxd0 = 1'b1;
        idle(20);
        chk("zero_fe_data", 32'(last_data), 32'h000);
        chk("zero_fe_flag", 32'(last_ferr), 32'd1);
`endif
        idle(20);

        // Stalled consumer: 0x11 held, 0x22 dropped with a single overrun pulse.
        rdy    = 1'b0;
        ov_cnt = 0;
        send(0, 9'h011, 1'b0, 1'b1, 1'b1);
        send(0, 9'h022, 1'b0, 1'b1, 1'b0);
        idle(20);
        chk("ovr_held_valid", 32'(v0), 32'd1);
        chk("ovr_held_data", 32'(d0), 32'h11);
        chk("ovr_pulse_count", 32'(ov_cnt), 32'd1);
        rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("ovr_accept_valid", 32'(v0), 32'd0);
        chk("ovr_accept_data", 32'(d0), 32'h11);
        idle(20);

        // 5-clk glitch: START entered, rejected at the start-bit sample point.
        rxd0 = 1'b0;
        idle(5);
        rxd0 = 1'b1;
        @(negedge clk);
        chk("glitch_busy", 32'(b0), 32'd1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("glitch_idle", 32'(b0), 32'd0);
        idle(20);
        send(0, 9'h055, 1'b0, 1'b1, 1'b1);
        idle(20);
        chk("post_glitch_data", 32'(last_data), 32'h055);

        // Reset during data bit 3 clears every output at once; nothing from that frame appears.
        @(posedge clk);
        #1;
        bit_out(0, 1'b0);
        bit_out(0, 1'b0);
        bit_out(0, 1'b1);
        bit_out(0, 1'b0);
        rxd0 = 1'b1;
        idle(8);
        chk("pre_reset_busy", 32'(b0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {26'd0, d0 == 8'h00, v0, pe0, fe0, ov0, b0}, 32'h20);
        idle(3);
        rst_n = 1'b1;
        idle(40);
        send(0, 9'h07E, 1'b0, 1'b1, 1'b1);
        idle(20);
        chk("post_reset_data", 32'(last_data), 32'h07E);
        chk("post_reset_flags", {30'd0, last_perr, last_ferr}, 32'd0);
        chk("queue_empty_end", 32'(expq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
